// File: rtl/solver_dispatch.sv
// solver_dispatch
//
// Hands endgame problems (player/opponent bitboards plus a tag) to a bank of
// NUM_CORES solver cores. It collects their signed scores and returns them on
// a single valid/ready result port. Results can come back out of order; the
// tag is the only thing that ties a result to its problem.
//
// Each core has one slot with a small FSM: IDLE -> RUN -> DONE -> IDLE.
// A new problem goes to the lowest-index IDLE slot. Finished slots are picked
// for output round-robin, starting one index past the last grant.
//
// Ports
//   iCLOCK, iRESET          clock; synchronous active-high reset
//   iValid/iPlayer/
//   iOpponent/iId           problem offer, accepted when oReady is high
//   oReady                  at least one slot is IDLE
//   oCoreStart              one-hot, one-cycle start pulse per core
//   oCorePlayer/
//   oCoreOpponent           shared operand bus, valid with a start bit
//   iCoreDone/iCoreRes      per-core completion pulse and signed score
//   oValid/oId/oRes/iReady  result port, held stable until iReady
//   oInFlight               number of slots in RUN or DONE
//   oErr                    sticky flag: a core finished while not running
module solver_dispatch #(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = 8
) (
    input  logic                             iCLOCK,
    input  logic                             iRESET,
    input  logic                             iValid,
    input  logic [63:0]                      iPlayer,
    input  logic [63:0]                      iOpponent,
    input  logic [ID_W-1:0]                  iId,
    output logic                             oReady,
    output logic [NUM_CORES-1:0]             oCoreStart,
    output logic [63:0]                      oCorePlayer,
    output logic [63:0]                      oCoreOpponent,
    input  logic [NUM_CORES-1:0]             iCoreDone,
    input  logic [8*NUM_CORES-1:0]           iCoreRes,
    output logic                             oValid,
    output logic [ID_W-1:0]                  oId,
    output logic [7:0]                       oRes,
    input  logic                             iReady,
    output logic [$clog2(NUM_CORES+1)-1:0]   oInFlight,
    output logic                             oErr
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(NUM_CORES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } slot_state_e;

    // Per-slot state
    slot_state_e              slot_q [NUM_CORES];
    slot_state_e              slot_d [NUM_CORES];
    logic [ID_W-1:0]          sid_q  [NUM_CORES];
    logic [ID_W-1:0]          sid_d  [NUM_CORES];
    logic signed [7:0]        sres_q [NUM_CORES];
    logic signed [7:0]        sres_d [NUM_CORES];

    // Core-side outputs
    logic [NUM_CORES-1:0]     start_q, start_d;
    logic [63:0]              player_q, player_d;
    logic [63:0]              opp_q, opp_d;

    // Result port and arbitration
    logic                     valid_q, valid_d;
    logic [ID_W-1:0]          oid_q, oid_d;
    logic signed [7:0]        ores_q, ores_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic                     err_q, err_d;

    // Combinational helpers
    logic                     idle_any;
    logic [IDX_W-1:0]         disp_idx;
    logic                     disp_found;
    logic                     sel_found;
    logic [IDX_W-1:0]         sel_idx;
    logic [IDX_W-1:0]         cand;
    int                       rr_j;
    logic [CNT_W-1:0]         busy_cnt;
    logic                     accept;
    logic                     handshake;

    // Lowest-index IDLE slot and the idle summary. Both are taken from
    // registered state only, so a slot freed at an edge is offered only
    // from the following cycle.
    always_comb begin
        idle_any   = 1'b0;
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (slot_q[k] == S_IDLE) begin
                idle_any = 1'b1;
                if (!disp_found) begin
                    disp_found = 1'b1;
                    disp_idx   = IDX_W'(k);
                end
            end
        end
    end

    // Round-robin search over DONE slots, starting one past the last grant.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        rr_j      = 0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            rr_j = int'(rr_q) + i;
            if (rr_j >= NUM_CORES) begin
                rr_j = rr_j - NUM_CORES;
            end
            cand = IDX_W'(rr_j);
            if (!sel_found && slot_q[cand] == S_DONE) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (slot_q[k] != S_IDLE) begin
                busy_cnt = busy_cnt + CNT_W'(1);
            end
        end
    end

    assign accept    = iValid && idle_any;
    assign handshake = valid_q && iReady;

    // Next-state logic. Dispatch, completion and result handshake touch
    // different slots, so all three can take effect at the same edge.
    always_comb begin
        slot_d   = slot_q;
        sid_d    = sid_q;
        sres_d   = sres_q;
        start_d  = '0;
        player_d = player_q;
        opp_d    = opp_q;
        valid_d  = valid_q;
        oid_d    = oid_q;
        ores_d   = ores_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        err_d    = err_q;

        if (accept) begin
            slot_d[disp_idx]  = S_RUN;
            sid_d[disp_idx]   = iId;
            start_d[disp_idx] = 1'b1;
            player_d          = iPlayer;
            opp_d             = iOpponent;
        end

        // A completion from a core that is not running is a protocol error.
        // It is flagged but does not change the slot.
        for (int k = 0; k < NUM_CORES; k++) begin
            if (iCoreDone[k]) begin
                if (slot_q[k] == S_RUN) begin
                    slot_d[k] = S_DONE;
                    sres_d[k] = iCoreRes[8*k +: 8];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // The granted slot stays DONE while it is presented and is released
        // by the handshake. A new grant is only made while the port is empty,
        // which leaves one idle cycle between consecutive results.
        if (handshake) begin
            valid_d         = 1'b0;
            slot_d[grant_q] = S_IDLE;
        end else if (!valid_q && sel_found) begin
            valid_d = 1'b1;
            oid_d   = sid_q[sel_idx];
            ores_d  = sres_q[sel_idx];
            grant_d = sel_idx;
            rr_d    = sel_idx;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                slot_q[k] <= S_IDLE;
                sid_q[k]  <= '0;
                sres_q[k] <= '0;
            end
            start_q  <= '0;
            player_q <= '0;
            opp_q    <= '0;
            valid_q  <= 1'b0;
            oid_q    <= '0;
            ores_q   <= '0;
            grant_q  <= '0;
            // Pointer at the last index makes slot 0 the first candidate.
            rr_q     <= IDX_W'(NUM_CORES - 1);
            err_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                slot_q[k] <= slot_d[k];
                sid_q[k]  <= sid_d[k];
                sres_q[k] <= sres_d[k];
            end
            start_q  <= start_d;
            player_q <= player_d;
            opp_q    <= opp_d;
            valid_q  <= valid_d;
            oid_q    <= oid_d;
            ores_q   <= ores_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
        end
    end

    assign oReady        = idle_any;
    assign oCoreStart    = start_q;
    assign oCorePlayer   = player_q;
    assign oCoreOpponent = opp_q;
    assign oValid        = valid_q;
    assign oId           = oid_q;
    assign oRes          = ores_q;
    assign oInFlight     = busy_cnt;
    assign oErr          = err_q;

endmodule

// File: tb/tb_solver_dispatch.sv
// Testbench for solver_dispatch (NUM_CORES=4, ID_W=8).
// Inputs change on the falling edge and outputs are sampled there too.
// Expected results go into a queue when a core completion is driven, and
// each one is popped and compared when the result port presents it.
module tb_solver_dispatch;
    localparam int NUM_CORES = 4;
    localparam int ID_W      = 8;

    logic                   iCLOCK = 1'b0;
    logic                   iRESET;
    logic                   iValid;
    logic [63:0]            iPlayer;
    logic [63:0]            iOpponent;
    logic [ID_W-1:0]        iId;
    logic                   oReady;
    logic [NUM_CORES-1:0]   oCoreStart;
    logic [63:0]            oCorePlayer;
    logic [63:0]            oCoreOpponent;
    logic [NUM_CORES-1:0]   iCoreDone;
    logic [8*NUM_CORES-1:0] iCoreRes;
    logic                   oValid;
    logic [ID_W-1:0]        oId;
    logic [7:0]             oRes;
    logic                   iReady;
    logic [2:0]             oInFlight;
    logic                   oErr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      res;
    } res_t;

    res_t exp_q[$];

    solver_dispatch #(.NUM_CORES(NUM_CORES), .ID_W(ID_W)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iValid(iValid), .iPlayer(iPlayer),
        .iOpponent(iOpponent), .iId(iId), .oReady(oReady), .oCoreStart(oCoreStart),
        .oCorePlayer(oCorePlayer), .oCoreOpponent(oCoreOpponent), .iCoreDone(iCoreDone),
        .iCoreRes(iCoreRes), .oValid(oValid), .oId(oId), .oRes(oRes), .iReady(iReady),
        .oInFlight(oInFlight), .oErr(oErr)
    );

    always #5 iCLOCK = ~iCLOCK;

    function automatic logic [63:0] pat_p(input int i);
        return 64'h0123_4567_89AB_CDEF ^ {8{8'(i)}};
    endfunction

    function automatic logic [63:0] pat_o(input int i);
        return 64'hFEDC_BA98_7654_3210 + 64'(i);
    endfunction

    task automatic cyc();
        @(negedge iCLOCK);
    endtask

    task automatic test_reset();
        iRESET = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", oReady); end
        n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", oValid); end
        n_cmp++; if (oCoreStart !== 4'b0000) begin n_bad++; $display("FAIL reset_start: got %0h want 0", oCoreStart); end
        n_cmp++; if (oInFlight !== 3'd0) begin n_bad++; $display("FAIL reset_inflight: got %0d want 0", oInFlight); end
        n_cmp++; if (oErr !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", oErr); end
        n_cmp++; if (oId !== 8'h00 || oRes !== 8'h00) begin n_bad++; $display("FAIL reset_result: got id %0h res %0h want 0 0", oId, oRes); end
        n_cmp++; if (oCorePlayer !== 64'h0 || oCoreOpponent !== 64'h0) begin n_bad++; $display("FAIL reset_bus: got %0h %0h want 0 0", oCorePlayer, oCoreOpponent); end
        iRESET = 1'b0;
    endtask

    // Five offers with iValid held; only four cores exist.
    task automatic test_dispatch();
        iValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            iId       = 8'(k + 1);
            iPlayer   = pat_p(k + 1);
            iOpponent = pat_o(k + 1);
            cyc();
            if (k < 4) begin
                n_cmp++; if (oCoreStart !== (4'b0001 << k)) begin n_bad++; $display("FAIL dispatch_start%0d: got %b want %b", k, oCoreStart, 4'b0001 << k); end
                n_cmp++; if (oCorePlayer !== pat_p(k + 1) || oCoreOpponent !== pat_o(k + 1)) begin n_bad++; $display("FAIL dispatch_bus%0d: got %0h %0h want %0h %0h", k, oCorePlayer, oCoreOpponent, pat_p(k + 1), pat_o(k + 1)); end
            end else begin
                n_cmp++; if (oCoreStart !== 4'b0000) begin n_bad++; $display("FAIL dispatch_full_start: got %b want 0000", oCoreStart); end
                n_cmp++; if (oCorePlayer !== pat_p(4) || oCoreOpponent !== pat_o(4)) begin n_bad++; $display("FAIL dispatch_bus_hold: got %0h %0h want %0h %0h", oCorePlayer, oCoreOpponent, pat_p(4), pat_o(4)); end
            end
            if (k == 3) begin
                n_cmp++; if (oReady !== 1'b0) begin n_bad++; $display("FAIL dispatch_full_ready: got %0b want 0", oReady); end
                n_cmp++; if (oInFlight !== 3'd4) begin n_bad++; $display("FAIL dispatch_inflight: got %0d want 4", oInFlight); end
            end
        end
    endtask

    // Core 2 then core 0 finish; id 5 is still offered and must land in
    // slot 2 one cycle after that slot's handshake.
    task automatic test_out_of_order();
        res_t e;
        int   got;
        iReady    = 1'b1;
        iCoreRes  = '0;
        iCoreDone = 4'b0100;
        iCoreRes[23:16] = 8'sd10;
        exp_q.push_back('{id: 8'd3, res: 8'sd10});
        cyc();
        iCoreDone = 4'b0000;
        cyc();
        e = exp_q.pop_front();
        n_cmp++; if (oValid !== 1'b1 || oId !== e.id || oRes !== e.res) begin n_bad++; $display("FAIL ooo_first: got v%0b id %0d res %0h want v1 id %0d res %0h", oValid, oId, oRes, e.id, e.res); end
        cyc();
        n_cmp++; if (oValid !== 1'b0 || oReady !== 1'b1 || oInFlight !== 3'd3) begin n_bad++; $display("FAIL ooo_freed: got v%0b rdy%0b inflight %0d want v0 rdy1 inflight 3", oValid, oReady, oInFlight); end
        n_cmp++; if (oCoreStart !== 4'b0000) begin n_bad++; $display("FAIL ooo_no_early_start: got %b want 0000", oCoreStart); end
        cyc();
        n_cmp++; if (oCoreStart !== 4'b0100 || oCorePlayer !== pat_p(5)) begin n_bad++; $display("FAIL ooo_redispatch: got %b %0h want 0100 %0h", oCoreStart, oCorePlayer, pat_p(5)); end
        iValid    = 1'b0;
        iCoreDone = 4'b0001;
        iCoreRes[7:0] = -8'sd6;
        exp_q.push_back('{id: 8'd1, res: -8'sd6});
        cyc();
        iCoreDone = 4'b0000;
        got = 0;
        for (int c = 0; c < 10 && got < 1; c++) begin
            cyc();
            if (oValid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                n_cmp++; if (oId !== e.id || oRes !== e.res) begin n_bad++; $display("FAIL ooo_second: got id %0d res %0h want id %0d res %0h", oId, oRes, e.id, e.res); end
            end
        end
        if (got < 1) begin n_cmp++; n_bad++; $display("FAIL ooo_timeout: got %0d results want 1", got); end
    endtask

    // Three cores finish together while the consumer stalls for 10 cycles.
    task automatic test_rr_stall();
        res_t e;
        int   got;
        int   last;
        iValid    = 1'b1;
        iId       = 8'd6;
        iPlayer   = pat_p(6);
        iOpponent = pat_o(6);
        cyc();
        cyc();
        n_cmp++; if (oCoreStart !== 4'b0001 || oInFlight !== 3'd4) begin n_bad++; $display("FAIL rr_setup: got %b inflight %0d want 0001 inflight 4", oCoreStart, oInFlight); end
        iValid    = 1'b0;
        iReady    = 1'b0;
        iCoreDone = 4'b1011;
        iCoreRes  = '0;
        iCoreRes[7:0]   = 8'sd20;
        iCoreRes[15:8]  = -8'sd30;
        iCoreRes[31:24] = 8'sd5;
        // Last grant was slot 0, so the search order is 1, 3, 0.
        exp_q.push_back('{id: 8'd2, res: -8'sd30});
        exp_q.push_back('{id: 8'd4, res: 8'sd5});
        exp_q.push_back('{id: 8'd6, res: 8'sd20});
        cyc();
        iCoreDone = 4'b0000;
        cyc();
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (oValid !== 1'b1 || oId !== e.id || oRes !== e.res) begin n_bad++; $display("FAIL rr_stall%0d: got v%0b id %0d res %0h want v1 id %0d res %0h", i, oValid, oId, oRes, e.id, e.res); end
            cyc();
        end
        iReady = 1'b1;
        got  = 0;
        last = 0;
        for (int c = 1; c <= 20 && got < 2; c++) begin
            cyc();
            if (oValid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                n_cmp++; if (oId !== e.id || oRes !== e.res) begin n_bad++; $display("FAIL rr_order%0d: got id %0d res %0h want id %0d res %0h", got, oId, oRes, e.id, e.res); end
                n_cmp++; if (c - last != 2) begin n_bad++; $display("FAIL rr_gap%0d: got spacing %0d want 2", got, c - last); end
                last = c;
            end
        end
        if (got < 2) begin n_cmp++; n_bad++; $display("FAIL rr_timeout: got %0d results want 2", got); end
    endtask

    // Extreme scores; the first completion coincides with a handshake.
    task automatic test_bounds();
        res_t e;
        int   got;
        iCoreRes  = '0;
        iCoreDone = 4'b0100;
        iCoreRes[23:16] = 8'hC0;
        exp_q.push_back('{id: 8'd5, res: 8'hC0});
        cyc();
        iCoreDone = 4'b0000;
        got = 0;
        for (int c = 0; c < 10 && got < 1; c++) begin
            cyc();
            if (oValid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                n_cmp++; if (oId !== e.id || oRes !== e.res) begin n_bad++; $display("FAIL bound_neg: got id %0d res %0h want id %0d res %0h", oId, oRes, e.id, e.res); end
            end
        end
        if (got < 1) begin n_cmp++; n_bad++; $display("FAIL bound_neg_timeout: got %0d want 1", got); end
        iValid = 1'b1;
        iId    = 8'd7;
        cyc();
        iValid = 1'b0;
        n_cmp++; if (oCoreStart !== 4'b0001) begin n_bad++; $display("FAIL bound_dispatch: got %b want 0001", oCoreStart); end
        iCoreDone = 4'b0001;
        iCoreRes[7:0] = 8'h40;
        exp_q.push_back('{id: 8'd7, res: 8'h40});
        cyc();
        iCoreDone = 4'b0000;
        got = 0;
        for (int c = 0; c < 10 && got < 1; c++) begin
            cyc();
            if (oValid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                n_cmp++; if (oId !== e.id || oRes !== e.res) begin n_bad++; $display("FAIL bound_pos: got id %0d res %0h want id %0d res %0h", oId, oRes, e.id, e.res); end
            end
        end
        if (got < 1) begin n_cmp++; n_bad++; $display("FAIL bound_pos_timeout: got %0d want 1", got); end
        cyc();
        n_cmp++; if (oInFlight !== 3'd0 || oErr !== 1'b0) begin n_bad++; $display("FAIL bound_drain: got inflight %0d err %0b want 0 0", oInFlight, oErr); end
    endtask

    task automatic test_err();
        iCoreDone = 4'b0010;
        cyc();
        iCoreDone = 4'b0000;
        n_cmp++; if (oErr !== 1'b1) begin n_bad++; $display("FAIL err_set: got %0b want 1", oErr); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++; if (oErr !== 1'b1 || oValid !== 1'b0 || oInFlight !== 3'd0) begin n_bad++; $display("FAIL err_sticky%0d: got err %0b v%0b inflight %0d want 1 0 0", i, oErr, oValid, oInFlight); end
        end
    endtask

    task automatic test_reset_mid();
        iRESET = 1'b1;
        cyc();
        iRESET = 1'b0;
        n_cmp++; if (oErr !== 1'b0) begin n_bad++; $display("FAIL rmid_err_clear: got %0b want 0", oErr); end
        iValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iId = 8'(10 + k);
            cyc();
        end
        iValid    = 1'b0;
        iReady    = 1'b0;
        iCoreRes  = '0;
        iCoreDone = 4'b0001;
        iCoreRes[7:0] = 8'sd33;
        cyc();
        iCoreDone = 4'b0000;
        cyc();
        n_cmp++; if (oValid !== 1'b1 || oId !== 8'd10 || oInFlight !== 3'd4) begin n_bad++; $display("FAIL rmid_setup: got v%0b id %0d inflight %0d want v1 id 10 inflight 4", oValid, oId, oInFlight); end
        // Reset must win over a simultaneous offer, completion and handshake.
        iRESET    = 1'b1;
        iValid    = 1'b1;
        iReady    = 1'b1;
        iCoreDone = 4'b0010;
        cyc();
        iRESET    = 1'b0;
        iValid    = 1'b0;
        n_cmp++; if (oValid !== 1'b0 || oInFlight !== 3'd0 || oReady !== 1'b1) begin n_bad++; $display("FAIL rmid_state: got v%0b inflight %0d rdy%0b want v0 inflight 0 rdy1", oValid, oInFlight, oReady); end
        n_cmp++; if (oRes !== 8'h00 || oId !== 8'h00 || oCoreStart !== 4'b0000 || oErr !== 1'b0) begin n_bad++; $display("FAIL rmid_outputs: got res %0h id %0h start %b err %0b want 0 0 0000 0", oRes, oId, oCoreStart, oErr); end
        iCoreDone = 4'b0010;
        cyc();
        iCoreDone = 4'b0000;
        n_cmp++; if (oErr !== 1'b1) begin n_bad++; $display("FAIL rmid_stale_done: got err %0b want 1", oErr); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_result%0d: got v%0b want 0", i, oValid); end
        end
    endtask

    initial begin
        iRESET    = 1'b1;
        iValid    = 1'b0;
        iPlayer   = '0;
        iOpponent = '0;
        iId       = '0;
        iCoreDone = '0;
        iCoreRes  = '0;
        iReady    = 1'b0;
        test_reset();
        test_dispatch();
        test_out_of_order();
        test_rr_stall();
        test_bounds();
        test_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/solver_dispatch.md
SOLVER_DISPATCH -- requirements
Module: solver_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 4, number of attached endgame solver cores (1..16).
REQ-002 Parameter ID_W, default 8, width of the problem tag.
REQ-003 iCLOCK  input  1  single clock; all state changes on its rising edge.
REQ-004 iRESET  input  1  reset, synchronous, active-high.
REQ-005 iValid  input  1  problem offered on iPlayer/iOpponent/iId.
REQ-006 iPlayer  input  64  player bitboard of offered problem.
REQ-007 iOpponent  input  64  opponent bitboard of offered problem.
REQ-008 iId  input  ID_W  tag returned with the problem's result.
REQ-009 oReady  output  1  dispatcher can accept a problem this cycle.
REQ-010 oCoreStart  output  NUM_CORES  one-hot, one-cycle start pulse to core k.
REQ-011 oCorePlayer  output  64  shared operand bus, player board; valid while a start bit is high.
REQ-012 oCoreOpponent  output  64  shared operand bus, opponent board.
REQ-013 iCoreDone  input  NUM_CORES  one-cycle completion pulse from core k.
REQ-014 iCoreRes  input  8*NUM_CORES  signed score of core k in bits [8k+7:8k], valid with iCoreDone[k].
REQ-015 oValid  output  1  result available on oId/oRes.
REQ-016 oId  output  ID_W  tag of the returned result.
REQ-017 oRes  output  8  signed two's-complement disc score, range -64..64.
REQ-018 iReady  input  1  consumer accepts the result.
REQ-019 oInFlight  output  clog2(NUM_CORES+1)  count of cores in RUN or DONE.
REQ-020 oErr  output  1  sticky protocol error flag.

Function
REQ-021 Each core slot SHALL hold a 3-state FSM: IDLE -> RUN (on dispatch) -> DONE (on iCoreDone) -> IDLE (on result handshake).
REQ-022 oReady SHALL equal OR of all slot IDLE flags, combinational from registered state only.
REQ-023 Accept: iValid & oReady at edge t SHALL move the lowest-index IDLE slot k to RUN, latch iId into slot k, and drive oCoreStart[k]=1 with the latched boards on oCorePlayer/oCoreOpponent during cycle t+1 only.
REQ-024 oCorePlayer/oCoreOpponent SHALL hold their last value when no start is pulsed; no more than one start bit SHALL be high per cycle.
REQ-025 iCoreDone[k] while slot k is RUN SHALL capture iCoreRes[k] into slot k and move it to DONE at that edge.
REQ-026 iCoreDone[k] while slot k is IDLE or DONE SHALL be ignored for state and SHALL set oErr.
REQ-027 Result output: when oValid=0 and any slot is DONE, the next edge SHALL load oId/oRes from the DONE slot selected round-robin starting at index (last granted + 1) mod NUM_CORES, and set oValid=1.
REQ-028 oValid/oId/oRes SHALL remain stable until iReady=1; the handshake edge SHALL clear oValid and return the granted slot to IDLE.
REQ-029 A slot freed by handshake at edge t SHALL be dispatchable from cycle t+1 (oReady reflects it then), never at edge t.
REQ-030 Dispatch, completion and result handshake on different slots in the same cycle SHALL all take effect at that edge.
REQ-031 Back-to-back results: after a handshake, the next DONE slot SHALL appear on oValid one cycle later (one idle cycle between results).
REQ-032 oInFlight SHALL equal the number of slots not IDLE, updated each edge.
REQ-033 Results may return out of dispatch order; iId is the only ordering information.

Reset
REQ-034 iRESET=1 at an edge SHALL set all slots IDLE, oCoreStart=0, oValid=0, oId=0, oRes=0, oCorePlayer=0, oCoreOpponent=0, oInFlight=0, oErr=0, round-robin pointer to index NUM_CORES-1 (so index 0 wins first).
REQ-035 Reset mid-operation SHALL discard all in-flight and pending results; iCoreDone pulses in the cycle after reset SHALL set oErr.
REQ-036 iRESET SHALL take priority over every other input in the same cycle.

Verification
REQ-037 Reset, then 5 problems with iValid held, ids 1..5, cores silent -> ids 1..4 start on cores 0..3 in consecutive cycles, oReady=0 after 4th accept, oInFlight=4.
REQ-038 Cores 2 then 0 pulse done with scores +10 and -6, iReady=1 -> oValid outputs (id 3, +10) then (id 1, -6); id 5 dispatched to core 0 or 2 (lowest free) one cycle after that slot's handshake.
REQ-039 Cores 0,1,3 done in same cycle, iReady held 0 for 10 cycles -> oValid stays high with first granted result unchanged; release gives round-robin order with one gap cycle each.
REQ-040 iCoreDone[1] while slot 1 IDLE -> oErr=1 and stays 1; no result produced.
REQ-041 Reset asserted with 3 slots RUN and oValid=1 -> next cycle oValid=0, oInFlight=0, oReady=1, oRes=0.
REQ-042 Score boundaries -64 and +64 returned by a core -> oRes equals 8'hC0 and 8'h40 exactly.
